// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared EX-stage definitions: ALUCtrl encodings, MDU state encoding and datapath width.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu_op(input logic [3:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
`timescale 1ns/1ps
// One radix-2 step, purely combinational: shift-add for MUL, restoring trial-subtract for DIV.
// MUL: {hi,lo} is the running product with the multiplier in lo; DIV: hi is remainder, lo shifts dividend out and quotient in.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, b});
    // When ge holds the difference is below the divisor, so the low WIDTH bits are exact.
    diff    = shifted[WIDTH-1:0] - b;
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (is_div) begin
      hi_nxt = ge ? diff : shifted[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ge};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
`timescale 1ns/1ps
// Multi-cycle unsigned MUL/DIV beside the EX-stage ALU; result valid WIDTH+1 cycles after accept (1 for divide-by-zero).
// Holds the pipeline via combinational stall_o until the single-cycle result pulse; flush aborts at any point.
module mdu_seq #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic             accept;
  logic             start_div;

  assign accept    = (state_q == IDLE) && start_i && is_mdu_op(ALUCtrl_i) && !flush_i;
  assign start_div = (ALUCtrl_i == ALU_DIV);

  assign stall_o = accept || ((state_q == RUN) && !flush_i);
  assign busy_o  = (state_q == RUN);
  assign valid_o = (state_q == DONE) && !flush_i;

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div (is_div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_o <= '0;
      hi_o     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_div_q <= start_div;
            cnt_q    <= '0;
            hi_q     <= '0;
            // DIV keeps the dividend in lo and divisor in b; MUL keeps the multiplier in lo.
            lo_q     <= start_div ? data1_i : data2_i;
            b_q      <= start_div ? data2_i : data1_i;
            if (start_div && (data2_i == '0)) begin
              result_o <= '1;
              hi_o     <= data1_i;
              state_q  <= DONE;
            end else begin
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              result_o <= lo_nxt;
              hi_o     <= hi_nxt;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer sitting beside the single-cycle ALU in the EX stage.
- Accepts MUL/DIV operations selected by the existing ALUCtrl encoding and runs a radix-2 iterative datapath: shift-add for MUL, restoring division for DIV.
- Holds the pipeline through a combinational stall output until the result is ready, then presents the result for exactly one cycle.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  EX stage holds a candidate instruction.
- ALUCtrl_i  input  4  operation code: 4'b0011 MUL, 4'b0111 DIV; all other codes are not handled by this block.
- data1_i  input  WIDTH  multiplicand / dividend (unsigned).
- data2_i  input  WIDTH  multiplier / divisor (unsigned).
- flush_i  input  1  pipeline flush; aborts any operation in progress.
- stall_o  output  1  freeze PC, IF/ID and ID/EX registers.
- busy_o  output  1  iteration in progress.
- valid_o  output  1  result_o and hi_o are valid this cycle.
- result_o  output  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient.
- hi_o  output  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder.

Behaviour:
- Reset (async, any state) forces:
  - state to IDLE, counter to 0, accumulator/quotient/remainder registers to 0;
  - stall_o, busy_o, valid_o to 0;
  - result_o and hi_o to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - accept = start_i && (ALUCtrl_i == MUL || ALUCtrl_i == DIV) && !flush_i.
  - On accept: latch operands and op, counter := 0, go to RUN.
  - Any other code: ignored, no stall.
- RUN:
  - One iteration per cycle; counter increments.
  - After iteration WIDTH-1 (counter == WIDTH-1), go to DONE.
  - Inputs are not re-sampled during RUN.
- DONE:
  - valid_o = 1 for exactly one cycle, then go to IDLE.
  - start_i is ignored in DONE, because it is still the same instruction leaving EX.
- Latency:
  - Accept at edge E0; iterations at edges E1..EWIDTH; valid_o is high in the cycle after edge EWIDTH.
  - For WIDTH=32: valid 33 cycles after accept. Minimum spacing between two accepts is WIDTH+2 cycles.
- stall_o (combinational) = accept-in-IDLE || state == RUN. It is low in DONE so the instruction advances with its result.
- busy_o = (state == RUN).
- result_o and hi_o hold their last values outside DONE; they are defined only while valid_o = 1.
- MUL: full 2*WIDTH unsigned product, no overflow flag.
- DIV by zero: do not iterate; go directly from IDLE to DONE on the next edge. Result: quotient = all ones, remainder = dividend; stall_o high only in the accept cycle.
- flush_i:
  - In RUN or DONE: next state IDLE, valid_o is forced 0 in that cycle, stall_o drops to 0 combinationally.
  - In IDLE: suppresses accept.
- A flush asserted together with a start in IDLE wins over the start.
- Counter width is clog2(WIDTH)+1; it never wraps within an operation.

Decomposition:
- Shared package (alu_pkg):
  - ALUCtrl encodings: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, MUL 4'b0011, DIV 4'b0111 (new);
  - mdu state enum {IDLE, RUN, DONE};
  - constant WIDTH = 32.
- One natural sub-module: mdu_iter.
  - Combinational single-step datapath: either add-and-shift the accumulator, or trial-subtract and shift the remainder/quotient.
  - mdu_seq owns the FSM, counter and registers.

Test Plan:
- Reset during RUN (rst_i pulsed at cycle 10 of a MUL) -> stall_o, busy_o, valid_o drop immediately; result_o = 0; a new start after reset completes normally.
- MUL 7 x 6 -> stall_o high for cycles 0..32, valid_o in cycle 33; result_o = 42, hi_o = 0. Also 0xFFFFFFFF x 0xFFFFFFFF -> hi_o = 0xFFFFFFFE, result_o = 0x00000001.
- DIV 100 / 7 -> valid_o 33 cycles after accept; result_o = 14, hi_o = 2. Also DIV 5 / 9 -> result_o = 0, hi_o = 5.
- DIV 1234 / 0 -> valid_o in the cycle after accept; result_o = 0xFFFFFFFF, hi_o = 1234; no RUN cycles.
- flush_i at cycle 5 of a DIV -> stall_o low in that cycle, valid_o never asserts, state is IDLE next edge.
- start_i held through DONE with ALUCtrl = MUL -> exactly one valid_o pulse, no restart. start_i with ALUCtrl = ADD (4'b0010) -> stall_o stays 0.
